// File: rtl/dmem_access_controller_pkg.sv
// dmem_access_controller_pkg: shared state encodings and defaults for the data-memory controller
package dmem_access_controller_pkg;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_WORD_SIZE = 16;
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_t;
endpackage

// File: rtl/dmem_access_controller_latency_counter.sv
// mem_latency_counter: loadable 4-bit down-counter with zero flag, shared with the fetch path
module mem_latency_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    cnt <= reset ? 4'd0 : load ? load_val : dec ? cnt - 4'd1 : cnt;
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/dmem_access_controller.sv
// dmem_access_controller: MEM-stage data-memory port with fixed-latency stall, load latch and access counters
module dmem_access_controller
  import dmem_access_controller_pkg::*;
#(
  parameter int LATENCY   = DEF_LATENCY,
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read_MEM,
  input  logic                 mem_write_MEM,
  input  logic [WORD_SIZE-1:0] addr_MEM,
  input  logic [WORD_SIZE-1:0] wdata_MEM,
  output logic                 d_readM,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  output logic [WORD_SIZE-1:0] d_wdata,
  input  logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_busy,
  output logic [WORD_SIZE-1:0] rdata_out,
  output logic                 rdata_valid,
  output logic [15:0]          num_reads,
  output logic [15:0]          num_writes
);
  dmem_state_t state;
  logic start, last, zero;
  assign start = state == DMEM_IDLE && (mem_read_MEM || mem_write_MEM);
  assign last = state == DMEM_BUSY && zero;
  assign mem_busy = start || state == DMEM_BUSY;
  mem_latency_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .dec      (state == DMEM_BUSY && !zero),
    .load_val (4'(LATENCY - 1)),
    .zero     (zero)
  );
  // d_writeM doubles as the latched op: it stays high for the whole BUSY window of a store
  always_ff @(posedge clk)
    if (reset) begin
      state <= DMEM_IDLE;
      d_readM <= 1'b0;
      d_writeM <= 1'b0;
      d_address <= '0;
      d_wdata <= '0;
      rdata_out <= '0;
      rdata_valid <= 1'b0;
      num_reads <= 16'd0;
      num_writes <= 16'd0;
    end else begin
      rdata_valid <= 1'b0;
      if (start) begin
        state <= DMEM_BUSY;
        d_readM <= !mem_write_MEM;
        d_writeM <= mem_write_MEM;
        d_address <= addr_MEM;
        d_wdata <= wdata_MEM;
      end else if (last) begin
        state <= DMEM_DONE;
        d_readM <= 1'b0;
        d_writeM <= 1'b0;
        rdata_valid <= !d_writeM;
        if (d_writeM)
          num_writes <= num_writes + 16'd1;
        else begin
          rdata_out <= d_rdata;
          num_reads <= num_reads + 16'd1;
        end
      end else if (state != DMEM_BUSY)
        state <= DMEM_IDLE;
    end
endmodule

// File: tb/tb_dmem_access_controller.sv
// tb_dmem_access_controller: directed scoreboard bench for LATENCY=4 and LATENCY=1 controllers
module tb_dmem_access_controller;
  import dmem_access_controller_pkg::*;
  logic clk = 1'b0, reset = 1'b1, sel = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0] addr = '0, wdata = '0, rdata_in = '0;
  logic rd4, wr4, busy4, v4, rd1, wr1, busy1, v1;
  logic [15:0] a4, w4, r4, nr4, nw4, a1, w1, r1, nr1, nw1;
  logic d_rd, d_wr, busy, valid;
  logic [15:0] d_addr, d_wd, rout, nr, nw;
  int tests = 0, fails = 0;
  logic [15:0] sb[$];
  always #5 clk = ~clk;
  dmem_access_controller #(.LATENCY(4), .WORD_SIZE(16)) dut4 (
    .clk(clk), .reset(reset), .mem_read_MEM(mem_read & !sel), .mem_write_MEM(mem_write & !sel),
    .addr_MEM(addr), .wdata_MEM(wdata), .d_readM(rd4), .d_writeM(wr4), .d_address(a4),
    .d_wdata(w4), .d_rdata(rdata_in), .mem_busy(busy4), .rdata_out(r4), .rdata_valid(v4),
    .num_reads(nr4), .num_writes(nw4));
  dmem_access_controller #(.LATENCY(1), .WORD_SIZE(16)) dut1 (
    .clk(clk), .reset(reset), .mem_read_MEM(mem_read & sel), .mem_write_MEM(mem_write & sel),
    .addr_MEM(addr), .wdata_MEM(wdata), .d_readM(rd1), .d_writeM(wr1), .d_address(a1),
    .d_wdata(w1), .d_rdata(rdata_in), .mem_busy(busy1), .rdata_out(r1), .rdata_valid(v1),
    .num_reads(nr1), .num_writes(nw1));
  assign d_rd = sel ? rd1 : rd4;
  assign d_wr = sel ? wr1 : wr4;
  assign busy = sel ? busy1 : busy4;
  assign valid = sel ? v1 : v4;
  assign d_addr = sel ? a1 : a4;
  assign d_wd = sel ? w1 : w4;
  assign rout = sel ? r1 : r4;
  assign nr = sel ? nr1 : nr4;
  assign nw = sel ? nw1 : nw4;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    mem_read = 1'b0;
    mem_write = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  // Request is held through BUSY and DONE like a stalled pipeline, with addr/data scrambled to
  // prove the bus comes from latches; memory data is only correct in the last BUSY cycle.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] rd, input int lat);
    int busy_n = 0, strobe_n = 0;
    mem_read = !w;
    mem_write = w;
    addr = a;
    wdata = wd;
    if (!w) sb.push_back(rd);
    for (int c = 0; c <= lat + 1; c++) begin
      rdata_in = c == lat ? rd : ~rd;
      if (c > 0) begin
        addr = ~a;
        wdata = ~wd;
      end
      @(negedge clk);
      busy_n += int'(busy);
      strobe_n += int'(w ? d_wr : d_rd);
      chk("mem_busy", 32'(busy), 32'(c <= lat));
      chk("d_readM", 32'(d_rd), 32'(!w && c >= 1 && c <= lat));
      chk("d_writeM", 32'(d_wr), 32'(w && c >= 1 && c <= lat));
      if (c >= 1 && c <= lat) begin
        chk("d_address", 32'(d_addr), 32'(a));
        if (w) chk("d_wdata", 32'(d_wd), 32'(wd));
      end
      chk("rdata_valid", 32'(valid), 32'(!w && c == lat + 1));
      if (valid) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("rdata_out", 32'(rout), 32'(sb.pop_front()));
      end
      step();
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    chk("busy_cycles", 32'(busy_n), 32'(lat + 1));
    chk("strobe_cycles", 32'(strobe_n), 32'(lat));
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    step();
    do_reset();
    @(negedge clk);
    chk("rst_state", 32'(dut4.state), 32'(DMEM_IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({d_rd, d_wr, valid}), 32'd0);
    chk("rst_bus", {d_addr, d_wd}, 32'd0);
    chk("rst_rdata", 32'(rout), 32'd0);
    chk("rst_counters", {nr, nw}, 32'd0);
    step();
    access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 4);
    chk("load_num_reads", 32'(nr), 32'd1);
    chk("load_rdata_hold", 32'(rout), 32'h0000BEEF);
    access(1'b1, 16'h0020, 16'h1234, 16'h5555, 4);
    chk("store_num_writes", 32'(nw), 32'd1);
    chk("store_rdata_hold", 32'(rout), 32'h0000BEEF);
    do_reset();
    access(1'b0, 16'h0030, 16'h0000, 16'hCAFE, 4);
    access(1'b1, 16'h0040, 16'h9999, 16'h3333, 4);
    chk("b2b_counters", {nr, nw}, {16'd1, 16'd1});
    chk("b2b_rdata", 32'(rout), 32'h0000CAFE);
    mem_read = 1'b1;
    addr = 16'h0050;
    rdata_in = 16'h7777;
    step();
    step();
    reset = 1'b1;
    mem_read = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_state", 32'(dut4.state), 32'(DMEM_IDLE));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_strobes", 32'({d_rd, d_wr, valid}), 32'd0);
    chk("abort_bus", {d_addr, d_wd}, 32'd0);
    chk("abort_rdata", 32'(rout), 32'd0);
    chk("abort_counters", {nr, nw}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_quiet", {15'd0, valid, nr}, 32'd0);
    end
    step();
    access(1'b0, 16'h0060, 16'h0000, 16'h4321, 4);
    chk("post_abort_reads", 32'(nr), 32'd1);
    sel = 1'b1;
    force dut1.num_reads = 16'hFFFF;
    step();
    release dut1.num_reads;
    chk("preload_reads", 32'(nr), 32'h0000FFFF);
    access(1'b0, 16'h0070, 16'h0000, 16'hA5A5, 1);
    chk("wrap_reads", 32'(nr), 32'd0);
    access(1'b1, 16'h0080, 16'h0F0F, 16'h0000, 1);
    chk("lat1_writes", 32'(nw), 32'd1);
    chk("lat1_rdata_hold", 32'(rout), 32'h0000A5A5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
